// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - scoreboard hazard unit: D-stage stall, D/E forwarding selects, mult/div busy, stall counter
module hazard_sb #(
  parameter int NRP      = 2,
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  localparam int SW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRP*AW-1:0] rd_addr_D,
  input  logic [NRP*TW-1:0] tuse_D,
  input  logic [AW-1:0]     dst_D,
  input  logic              wr_D,
  input  logic [TW-1:0]     tnew_D,
  input  logic              ismd_D,
  input  logic              md_start_E,
  input  logic              md_div_E,
  output logic              stall,
  output logic [NRP*SW-1:0] fwd_sel_D,
  output logic [NRP*SW-1:0] fwd_sel_E,
  output logic              md_busy,
  output logic [31:0]       stall_cnt
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic          v_q  [DEPTH];
  logic [AW-1:0] rd_q [DEPTH];
  logic [TW-1:0] tn_q [DEPTH];
  logic [AW-1:0] ea_q [NRP];
  logic [CW-1:0] md_cnt;
  logic [NRP-1:0] port_stall;

  assign md_busy = (md_cnt != '0);

  // Slots are scanned oldest to youngest so the youngest matching writer overwrites older ones.
  always_comb begin
    logic          hit_d, hit_e;
    logic [SW-1:0] k_d, k_e;
    logic [TW-1:0] t_d, t_e;
    logic [AW-1:0] a_d;
    logic [TW-1:0] tu;
    port_stall = '0;
    fwd_sel_D  = '0;
    fwd_sel_E  = '0;
    for (int p = 0; p < NRP; p++) begin
      a_d   = rd_addr_D[p*AW +: AW];
      tu    = tuse_D[p*TW +: TW];
      hit_d = 1'b0;
      k_d   = '0;
      t_d   = '0;
      hit_e = 1'b0;
      k_e   = '0;
      t_e   = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (v_q[k] && rd_q[k] == a_d && a_d != '0) begin
          hit_d = 1'b1;
          k_d   = SW'(k);
          t_d   = tn_q[k];
        end
      end
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (v_q[k] && rd_q[k] == ea_q[p] && ea_q[p] != '0) begin
          hit_e = 1'b1;
          k_e   = SW'(k);
          t_e   = tn_q[k];
        end
      end
      port_stall[p] = hit_d && ((t_d > tu) || (k_d == '0 && tu == '0));
      if (hit_d && k_d != '0 && t_d == '0)
        fwd_sel_D[p*SW +: SW] = k_d;
      if (hit_e && t_e == '0)
        fwd_sel_E[p*SW +: SW] = k_e;
    end
    stall = (|port_stall) || (ismd_D && (md_busy || md_start_E));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k]  <= 1'b0;
        rd_q[k] <= '0;
        tn_q[k] <= '0;
      end
      for (int p = 0; p < NRP; p++)
        ea_q[p] <= '0;
      md_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      v_q[0]  <= wr_D && (dst_D != '0) && !stall;
      rd_q[0] <= dst_D;
      tn_q[0] <= tnew_D;
      for (int k = 0; k < DEPTH - 1; k++) begin
        v_q[k+1]  <= v_q[k];
        rd_q[k+1] <= rd_q[k];
        tn_q[k+1] <= (tn_q[k] == '0) ? '0 : tn_q[k] - TW'(1);
      end
      // A stalled D instruction enters E as a bubble, so its operands must not match.
      for (int p = 0; p < NRP; p++)
        ea_q[p] <= stall ? '0 : rd_addr_D[p*AW +: AW];
      if (md_start_E)
        md_cnt <= md_div_E ? CW'(DIV_LAT) : CW'(MULT_LAT);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - CW'(1);
      if (stall && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
